serial_tx: RTL

UART-style asynchronous serial transmitter: the send side of the console/debug serial link whose receive side is sampled by the 8N1 receiver. It accepts bytes on a simple write strobe into a small FIFO and shifts each one out LSB-first as start bit, 8 data bits, optional parity bit, stop bit. Line idles high. Sits between the host-side register interface and the board TX pin.

---
 rtl/serial_tx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// UART-style 8N1 transmitter with a small byte FIFO; line idles high, data LSB-first.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx #(
  parameter int CLK_PER_BIT = 434,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       wr,
  input  logic       block,
  output logic       full,
  output logic       busy,
  output logic       tx
);

  localparam int CYC_W = $clog2(CLK_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
  } state_t;
`endif

  state_t           state_r, state_s;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_r, rptr_r;
  logic [CNT_W-1:0] count_r, count_s;
  logic [CYC_W-1:0] cyc_r, cyc_s;
  logic [2:0]       bit_r, bit_s;
  logic [7:0]       shift_r, shift_s;
  logic             full_r, busy_r, tx_r, tx_s;
  logic             push_s, pop_s, cyc_last_s, can_start_s;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_r, par_s;
`endif

  assign full = full_r;
  assign busy = busy_r;
  assign tx   = tx_r;

  assign push_s      = wr && !full_r;
  assign cyc_last_s  = (cyc_r == CYC_LAST);
  assign can_start_s = (count_r != {CNT_W{1'b0}}) && !block;

  // Frame sequencer: next state, bit timing, FIFO pop and line level
  always_comb begin
    state_s = state_r;
    cyc_s   = cyc_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
    tx_s    = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (can_start_s) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rptr_r];
`ifdef SERIAL_TX_PARITY_EN
          par_s   = even_parity(mem_r[rptr_r]);
`endif
          cyc_s   = {CYC_W{1'b0}};
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        tx_s = 1'b0;
        if (cyc_last_s) begin
          cyc_s   = {CYC_W{1'b0}};
          bit_s   = 3'd0;
          state_s = DATA;
        end else begin
          cyc_s = cyc_r + CYC_W'(1);
        end
      end
      DATA: begin
        tx_s = shift_r[0];
        if (cyc_last_s) begin
          cyc_s   = {CYC_W{1'b0}};
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            bit_s = 3'd0;
`ifdef SERIAL_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          cyc_s = cyc_r + CYC_W'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        tx_s = par_r;
        if (cyc_last_s) begin
          cyc_s   = {CYC_W{1'b0}};
          state_s = STOP;
        end else begin
          cyc_s = cyc_r + CYC_W'(1);
        end
      end
`endif
      STOP: begin
        tx_s = 1'b1;
        if (cyc_last_s) begin
          cyc_s = {CYC_W{1'b0}};
          // Chain straight into the next start bit when a byte is waiting
          if (can_start_s) begin
            pop_s   = 1'b1;
            shift_s = mem_r[rptr_r];
`ifdef SERIAL_TX_PARITY_EN
            par_s   = even_parity(mem_r[rptr_r]);
`endif
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cyc_s = cyc_r + CYC_W'(1);
        end
      end
      default: begin
        tx_s    = 1'b1;
        cyc_s   = {CYC_W{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wptr_r] <= data;
  end

  // State, counters, pointers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cyc_r   <= {CYC_W{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      full_r  <= 1'b0;
      busy_r  <= 1'b0;
      tx_r    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cyc_r   <= cyc_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      if (push_s) wptr_r <= wptr_r + PTR_W'(1);
      if (pop_s)  rptr_r <= rptr_r + PTR_W'(1);
      count_r <= count_s;
      full_r  <= (count_s == CNT_FULL);
      busy_r  <= (state_s != IDLE) || (count_s != {CNT_W{1'b0}});
      tx_r    <= tx_s;
`ifdef SERIAL_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

endmodule
